// File: rtl/adc_sampler.sv
// ADC acquisition front end: one DRP read per end-of-conversion, runtime decimation, 8-bit output.
// Define ADC_AVG_EN to output a 4-conversion moving sum instead of plain truncation (+1 cycle).
module adc_sampler #(
   parameter logic [6:0]  DADDR       = 7'h03,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned RDY_TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] timebase,
   input  logic             adc_eoc,
   output logic             adc_den,
   output logic [6:0]       adc_daddr,
   input  logic             adc_drdy,
   input  logic [15:0]      adc_do,
   output logic [7:0]       data_input,
   output logic             data_valid,
   output logic             overrun,
   output logic             timeout
);

   localparam int unsigned CntW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
   localparam logic [CntW-1:0] RdyLast = CntW'(RDY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitEoc,
      StWaitRdy,
      StDecide
`ifdef ADC_AVG_EN
      , StSum
`endif
   } state_e;

   state_e           state_q;
   logic [CntW-1:0]  rdy_cnt_q;
   logic [DIV_W-1:0] decim_cnt_q;
   logic [7:0]       sample_q;
   logic             drop_q;

`ifdef ADC_AVG_EN
   logic [3:0][11:0] hist_q;
   logic [13:0]      hist_sum;
   logic             unused_do_lsb;

   assign hist_sum = 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]) + 14'(hist_q[3]);
   assign unused_do_lsb = ^adc_do[3:0];
`else
   logic             unused_do_lsb;

   assign unused_do_lsb = ^adc_do[7:0];
`endif

   assign adc_daddr = DADDR;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         adc_den     <= 1'b0;
         data_input  <= 8'h00;
         data_valid  <= 1'b0;
         overrun     <= 1'b0;
         timeout     <= 1'b0;
         decim_cnt_q <= '0;
         rdy_cnt_q   <= '0;
         sample_q    <= 8'h00;
         drop_q      <= 1'b0;
`ifdef ADC_AVG_EN
         hist_q      <= '0;
`endif
      end else begin
         adc_den    <= 1'b0;
         data_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               decim_cnt_q <= '0;
               overrun     <= 1'b0;
               timeout     <= 1'b0;
               drop_q      <= 1'b0;
`ifdef ADC_AVG_EN
               hist_q      <= '0;
`endif
               if (enable) state_q <= StWaitEoc;
            end
            StWaitEoc: begin
               if (!enable) begin
                  state_q <= StIdle;
               end else if (adc_eoc) begin
                  adc_den   <= 1'b1;
                  rdy_cnt_q <= '0;
                  drop_q    <= 1'b0;
                  state_q   <= StWaitRdy;
               end
            end
            StWaitRdy: begin
               if (adc_eoc) overrun <= 1'b1;
               // Remember a disable seen mid-read so the result is discarded on completion
               if (!enable) drop_q <= 1'b1;
               if (adc_drdy) begin
`ifdef ADC_AVG_EN
                  hist_q <= {hist_q[2:0], adc_do[15:4]};
`else
                  sample_q <= adc_do[15:8];
`endif
                  if (!enable || drop_q) begin
                     state_q <= StIdle;
                  end else begin
`ifdef ADC_AVG_EN
                     state_q <= StSum;
`else
                     state_q <= StDecide;
`endif
                  end
               end else if (rdy_cnt_q == RdyLast) begin
                  timeout <= 1'b1;
                  state_q <= (!enable || drop_q) ? StIdle : StWaitEoc;
               end else begin
                  rdy_cnt_q <= rdy_cnt_q + 1'b1;
               end
            end
`ifdef ADC_AVG_EN
            StSum: begin
               if (adc_eoc) overrun <= 1'b1;
               sample_q <= hist_sum[13:6];
               state_q  <= StDecide;
            end
`endif
            StDecide: begin
               if (adc_eoc) overrun <= 1'b1;
               // >= lets a lowered timebase take effect on the very next conversion
               if (decim_cnt_q >= timebase) begin
                  data_input  <= sample_q;
                  data_valid  <= 1'b1;
                  decim_cnt_q <= '0;
               end else begin
                  decim_cnt_q <= decim_cnt_q + 1'b1;
               end
               state_q <= enable ? StWaitEoc : StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
